// File: rtl/pp_accum_seq_pkg.sv
// rtl/pp_accum_seq_pkg.sv - shared types and defaults for the partial-product accumulator
// Purpose: FSM state enum and default WIDTH/ROWS used by pp_accum_seq and its bench.
// Ports: none (package).
package pp_acc_pkg;

  localparam int PP_ACC_WIDTH = 128;
  localparam int PP_ACC_ROWS  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } pp_acc_state_t;

endpackage

// File: rtl/pp_accum_seq_if.sv
// rtl/pp_accum_seq_if.sv - row-in / sum-out handshake bundle for pp_accum_seq
// Purpose: groups the input row stream and the result handshake.
// Ports (master = row generator + product register side, slave = accumulator):
//   in_valid/in_row/in_last (m->s), in_ready (s->m),
//   out_valid/out_sum/out_rows/out_trunc (s->m), out_ready (m->s).
interface pp_accum_seq_if #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 6
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_row;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_rows;
  logic             out_trunc;

  modport master (
    output in_valid, in_row, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_rows, out_trunc
  );

  modport slave (
    input  in_valid, in_row, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_rows, out_trunc
  );

endinterface

// File: rtl/pp_accum_seq_csa.sv
// rtl/pp_accum_seq_csa.sv - bitwise 3:2 carry-save compressor
// Purpose: sum = a^b^c, carry = maj(a,b,c) shifted up one bit (top carry dropped).
// Only compiled when PP_ACC_CSA_EN is defined; the direct-add build has no use for it.
// Ports: a, b, c (in, WIDTH), sum, carry (out, WIDTH).
`ifdef PP_ACC_CSA_EN
module csa_3to2 #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule
`endif

// File: rtl/pp_accum_seq.sv
// rtl/pp_accum_seq.sv - sequential partial-product accumulator (top)
// Purpose: accumulates one WIDTH-bit row per cycle; a product closes on in_last or
//   after ROWS rows (out_trunc=1), and the modulo-2^WIDTH sum is held until out_ready.
// Config macro PP_ACC_CSA_EN: defined -> carry-save accumulation plus a RESOLVE cycle
//   (last row to out_valid = 2 cycles); undefined -> direct add per row (1 cycle).
// Ports: clk, rst_n (sync, active-low), bus (pp_accum_seq_if.slave).
module pp_accum_seq
  import pp_acc_pkg::*;
#(
  parameter int WIDTH = PP_ACC_WIDTH,
  parameter int ROWS  = PP_ACC_ROWS,
  parameter int CNT_W = $clog2(ROWS + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  pp_accum_seq_if.slave  bus
);

  pp_acc_state_t    state_q, state_d;
  logic [WIDTH-1:0] s_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] rows_q;
  logic             trunc_out_q;

  logic             in_ready;
  logic             accept;
  logic             close;
  logic [WIDTH-1:0] s_base, s_new;
  logic [CNT_W-1:0] cnt_base, cnt_new;

  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign accept   = bus.in_valid && in_ready;

  // Treating IDLE as "empty accumulator" makes the first row use the same
  // datapath as every other row: S=row, C=0, cnt=1 fall out naturally.
  assign s_base   = (state_q == IDLE) ? '0 : s_q;
  assign cnt_base = (state_q == IDLE) ? '0 : cnt_q;
  assign cnt_new  = cnt_base + CNT_W'(1);
  assign close    = bus.in_last || (cnt_new == CNT_W'(ROWS));

`ifdef PP_ACC_CSA_EN
  localparam pp_acc_state_t CLOSE_ST = RESOLVE;

  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] c_base, c_new;
  logic             trunc_q;

  assign c_base = (state_q == IDLE) ? '0 : c_q;

  csa_3to2 #(.WIDTH(WIDTH)) u_csa (
    .a     (s_base),
    .b     (c_base),
    .c     (bus.in_row),
    .sum   (s_new),
    .carry (c_new)
  );
`else
  localparam pp_acc_state_t CLOSE_ST = DONE;

  assign s_new = s_base + bus.in_row;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: if (accept) state_d = close ? CLOSE_ST : ACCUM;
      RESOLVE:     state_d = DONE;
      DONE:        if (bus.out_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      rows_q      <= '0;
      trunc_out_q <= 1'b0;
`ifdef PP_ACC_CSA_EN
      c_q         <= '0;
      trunc_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        s_q   <= s_new;
        cnt_q <= cnt_new;
`ifdef PP_ACC_CSA_EN
        c_q     <= c_new;
        trunc_q <= !bus.in_last;
`else
        if (close) begin
          sum_q       <= s_new;
          rows_q      <= cnt_new;
          trunc_out_q <= !bus.in_last;
        end
`endif
      end
`ifdef PP_ACC_CSA_EN
      // Single carry-propagate add; the carry-out beyond WIDTH is discarded.
      if (state_q == RESOLVE) begin
        sum_q       <= s_q + c_q;
        rows_q      <= cnt_q;
        trunc_out_q <= trunc_q;
      end
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_rows  = rows_q;
  assign bus.out_trunc = trunc_out_q;

endmodule
